// File: rtl/dma_pkg.sv
// Shared definitions for the DMA chain sequencer: register map, FSM encoding, STAT layout.
package dma_pkg;

    localparam logic [13:0] AdrCtrl   = 14'h3FE0;
    localparam logic [13:0] AdrDioa   = 14'h3FE1;
    localparam logic [13:0] AdrDmea   = 14'h3FE2;
    localparam logic [13:0] AdrDcnt   = 14'h3FE3;

    localparam logic [13:0] DmaAdrGo  = 14'h3FF0;
    localparam logic [13:0] DmaAdrIoa = 14'h3FF1;
    localparam logic [13:0] DmaAdrMea = 14'h3FF2;
    localparam logic [13:0] DmaAdrCnt = 14'h3FF3;

    localparam int unsigned StatEnBit    = 0;
    localparam int unsigned StatIrqEnBit = 1;
    localparam int unsigned StatDoneBit  = 2;
    localparam int unsigned StatBusyBit  = 3;
    localparam int unsigned StatCntLsb   = 4;
    localparam int unsigned StatOvfBit   = 7;
    localparam int unsigned CtrlClrBit   = 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWIoa    = 3'd1,
        StWMea    = 3'd2,
        StWCnt    = 3'd3,
        StWGo     = 3'd4,
        StWSettle = 3'd5,
        StWDone   = 3'd6
    } seq_state_e;

    // GO register value: bit0 starts an io->mem read, bit1 a mem->io write.
    function automatic logic [31:0] go_word(input logic dir);
        return dir ? 32'h2 : 32'h1;
    endfunction

endpackage

// File: rtl/dma_chain_seq_if.sv
// CPU io bus plus the merged write bus and status lines towards the DMA engine.
interface dma_chain_seq_if;
    logic        io_we;
    logic [15:2] io_wadr;
    logic [31:0] io_wdata;
    logic [15:2] io_radr;
    logic [31:0] io_rdata_in;
    logic [31:0] io_rdata;
    logic        dma_io_we;
    logic [15:2] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic        dma_read_run;
    logic        dma_write_run;
    logic        seq_irq;

    modport slave (
        input  io_we, io_wadr, io_wdata, io_radr, io_rdata_in, dma_read_run, dma_write_run,
        output io_rdata, dma_io_we, dma_io_wadr, dma_io_wdata, seq_irq
    );

    modport master (
        output io_we, io_wadr, io_wdata, io_radr, io_rdata_in, dma_read_run, dma_write_run,
        input  io_rdata, dma_io_we, dma_io_wadr, dma_io_wdata, seq_irq
    );
endinterface

// File: rtl/dma_desc_fifo.sv
// Descriptor queue; a push into a full queue is taken only when a pop happens in the same cycle.
module dma_desc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] DepthCnt = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/dma_chain_seq.sv
// Chains queued DMA descriptors: programs IOA/MEA/CNT then GO into the DMA config registers,
// stealing bus cycles only when the CPU is not writing.
module dma_chain_seq
    import dma_pkg::*;
#(
    parameter int unsigned DWIDTH = 11,
    parameter int unsigned QDEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rst_pipe,
    dma_chain_seq_if.slave bus
);
    localparam int unsigned CW    = $clog2(QDEPTH) + 1;
    localparam int unsigned DescW = 2 * DWIDTH + 20;

    logic              enable_q, irq_en_q, done_q, ovf_q;
    logic [17:0]       dioa_q;
    logic [DWIDTH-1:0] dmea_q;
    seq_state_e        state_q;
    logic [DescW-1:0]  cur_q, head, new_desc;
    logic              full, empty;
    logic [CW-1:0]     count;
    logic              rd_hit_q;
    logic [1:0]        rd_sel_q;

    logic wr_ctrl, wr_dioa, wr_dmea, wr_dcnt, clr_flags, pop, done_set;
    logic seq_we;
    logic [13:0] seq_adr;
    logic [31:0] seq_data, stat, local_rdata;

    assign wr_ctrl   = bus.io_we && (bus.io_wadr == AdrCtrl);
    assign wr_dioa   = bus.io_we && (bus.io_wadr == AdrDioa);
    assign wr_dmea   = bus.io_we && (bus.io_wadr == AdrDmea);
    assign wr_dcnt   = bus.io_we && (bus.io_wadr == AdrDcnt);
    assign clr_flags = wr_ctrl && bus.io_wdata[CtrlClrBit];
    assign pop       = (state_q == StIdle) && enable_q && !empty;
    assign done_set  = (state_q == StWDone) && !bus.dma_read_run && !bus.dma_write_run && empty;
    // Descriptor layout: {ioa[17:0], mea[DWIDTH-1:0], cnt[DWIDTH:0], dir}
    assign new_desc  = {dioa_q, dmea_q, bus.io_wdata[DWIDTH:0], bus.io_wdata[31]};

    dma_desc_fifo #(
        .WIDTH (DescW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rst_pipe),
        .push  (wr_dcnt),
        .pop   (pop),
        .din   (new_desc),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            dioa_q   <= '0;
            dmea_q   <= '0;
            rd_hit_q <= 1'b0;
            rd_sel_q <= '0;
        end else if (rst_pipe) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            dioa_q   <= '0;
            dmea_q   <= '0;
            rd_hit_q <= 1'b0;
            rd_sel_q <= '0;
        end else begin
            if (wr_ctrl) begin
                enable_q <= bus.io_wdata[0];
                irq_en_q <= bus.io_wdata[1];
            end
            if (wr_dioa) dioa_q <= bus.io_wdata[19:2];
            if (wr_dmea) dmea_q <= bus.io_wdata[DWIDTH+1:2];
            if (wr_dcnt && full && !pop) ovf_q <= 1'b1;
            else if (clr_flags)          ovf_q <= 1'b0;
            rd_hit_q <= (bus.io_radr[15:4] == AdrCtrl[13:2]);
            rd_sel_q <= bus.io_radr[3:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cur_q   <= '0;
            done_q  <= 1'b0;
        end else if (rst_pipe) begin
            state_q <= StIdle;
            cur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            if (clr_flags) done_q <= 1'b0;
            if (done_set)  done_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        cur_q   <= head;
                        state_q <= StWIoa;
                    end
                end
                StWIoa:    if (!bus.io_we) state_q <= StWMea;
                StWMea:    if (!bus.io_we) state_q <= StWCnt;
                StWCnt:    if (!bus.io_we) state_q <= StWGo;
                StWGo:     if (!bus.io_we) state_q <= StWSettle;
                StWSettle: state_q <= StWDone;
                StWDone:   if (!bus.dma_read_run && !bus.dma_write_run) state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        seq_we   = 1'b0;
        seq_adr  = DmaAdrGo;
        seq_data = '0;
        case (state_q)
            StWIoa: begin
                seq_we   = 1'b1;
                seq_adr  = DmaAdrIoa;
                seq_data = {12'b0, cur_q[DescW-1 -: 18], 2'b00};
            end
            StWMea: begin
                seq_we   = 1'b1;
                seq_adr  = DmaAdrMea;
                seq_data = 32'({cur_q[2*DWIDTH+1:DWIDTH+2], 2'b00});
            end
            StWCnt: begin
                seq_we   = 1'b1;
                seq_adr  = DmaAdrCnt;
                seq_data = 32'(cur_q[DWIDTH+1:1]);
            end
            StWGo: begin
                seq_we   = 1'b1;
                seq_adr  = DmaAdrGo;
                seq_data = go_word(cur_q[0]);
            end
            default: ;
        endcase
    end

    // CPU always owns the bus in its write cycles; the FSM holds state until a free cycle.
    assign bus.dma_io_we    = bus.io_we | seq_we;
    assign bus.dma_io_wadr  = bus.io_we ? bus.io_wadr  : seq_adr;
    assign bus.dma_io_wdata = bus.io_we ? bus.io_wdata : seq_data;
    assign bus.seq_irq      = done_q & irq_en_q;

    always_comb begin
        stat                           = '0;
        stat[StatEnBit]                = enable_q;
        stat[StatIrqEnBit]             = irq_en_q;
        stat[StatDoneBit]              = done_q;
        stat[StatBusyBit]              = (state_q != StIdle);
        stat[StatCntLsb +: 3]          = 3'(count);
        stat[StatOvfBit]               = ovf_q;
        case (rd_sel_q)
            2'd0:    local_rdata = stat;
            2'd1:    local_rdata = {12'b0, dioa_q, 2'b00};
            2'd2:    local_rdata = 32'({dmea_q, 2'b00});
            default: local_rdata = '0;
        endcase
    end

    assign bus.io_rdata = rd_hit_q ? local_rdata : bus.io_rdata_in;
endmodule

// File: doc/dma_chain_seq.md
DMA_CHAIN_SEQ -- requirements
Module: dma_chain_seq

Interface
REQ-001 SHALL have parameter DWIDTH, default 11, DMA memory word-address width (count width DWIDTH+1).
REQ-002 SHALL have parameter QDEPTH, default 4, descriptor queue depth (power of two).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rst_pipe  input  1  synchronous pipeline reset.
REQ-006 io_we  input  1  CPU io write strobe.
REQ-007 io_wadr  input  [15:2]  CPU io write word address.
REQ-008 io_wdata  input  32  CPU io write data.
REQ-009 io_radr  input  [15:2]  CPU io read word address.
REQ-010 io_rdata_in  input  32  upstream read data, chained.
REQ-011 io_rdata  output  32  read data to CPU.
REQ-012 dma_io_we / dma_io_wadr[15:2] / dma_io_wdata[32]  output  merged write bus to DMA config registers.
REQ-013 dma_read_run, dma_write_run  input  1 each  DMA busy status bits.
REQ-014 seq_irq  output  1  level interrupt, done AND irq enable.

Function
REQ-015 Register map: 14'h3FE0 CTRL/STAT, 3FE1 DIOA (io byte adr [19:2]), 3FE2 DMEA (mem byte adr [DWIDTH+1:2]), 3FE3 DCNT (write pushes descriptor).
REQ-016 DCNT write: bits[DWIDTH:0] count, bit31 dir (0 io->mem "read", 1 mem->io "write"); pushes {DIOA, DMEA, count, dir}.
REQ-017 Push when queue full SHALL be dropped and set sticky ovf.
REQ-018 CTRL write: bit0 enable, bit1 irq_en stored; bit2=1 clears done and ovf (write-one-to-clear).
REQ-019 STAT read: {bit0 enable, bit1 irq_en, bit2 done, bit3 busy, bits[6:4] queue count, bit7 ovf, rest 0}.
REQ-020 Reads SHALL be registered one cycle (address decode flopped), own address hit selects local data, else io_rdata_in.
REQ-021 CPU writes SHALL pass through to dma_io_* unchanged in the same cycle; sequencer writes SHALL drive the bus only when io_we=0.
REQ-022 FSM states: IDLE, W_IOA, W_MEA, W_CNT, W_GO, W_SETTLE, W_DONE.
REQ-023 IDLE -> W_IOA when enable=1 and queue non-empty; head descriptor popped and latched on that transition.
REQ-024 W_IOA/W_MEA/W_CNT/W_GO each issue one write to 3FF1/3FF2/3FF3/3FF0 (GO data 32'h1 dir0, 32'h2 dir1), advancing only in a cycle with io_we=0; otherwise hold.
REQ-025 W_GO -> W_SETTLE unconditionally after its write; W_SETTLE lasts exactly one cycle -> W_DONE.
REQ-026 W_DONE -> IDLE when dma_read_run=0 and dma_write_run=0; done set in that cycle if queue empty, else next descriptor starts from IDLE.
REQ-027 busy = state != IDLE.
REQ-028 Clearing enable mid-chain SHALL finish current descriptor, then stop in IDLE; queue retained.
REQ-029 Simultaneous push and pop SHALL keep count unchanged; push when full and pop same cycle SHALL be accepted.
REQ-030 Queue pointers wrap modulo QDEPTH; count width log2(QDEPTH)+1.
REQ-031 Count value 0 SHALL still be sequenced (DMA completes immediately).
REQ-032 Simultaneous done-clear write and done-set: set wins.

Reset
REQ-033 rst_n low: FSM IDLE, queue empty, enable/irq_en/done/ovf 0, DIOA/DMEA 0, io_rdata select flops 0, dma_io_we 0, seq_irq 0.
REQ-034 rst_pipe: same as rst_n, synchronously, including abort mid-descriptor.

Structure
REQ-035 Register addresses, FSM state encoding, STAT bit positions SHALL live in shared package dma_pkg.
REQ-036 Descriptor queue SHALL be sub-module dma_desc_fifo (push/pop/full/empty/count).

Verification
REQ-037 Push 1 desc (DIOA 0x100, DMEA 0x40, cnt 8, dir0), enable -> four bus writes 3FF1=0x100,3FF2=0x40,3FF3=8,3FF0=1 consecutive; done=1 after run falls.
REQ-038 Queue 3 descs, irq_en=1 -> three sequences in order, seq_irq rises only after third, clears on CTRL bit2 write.
REQ-039 CPU io_we every other cycle during sequencing -> seq writes only in gaps, none lost, CPU writes unaltered.
REQ-040 Push 5 with QDEPTH=4 -> STAT count 4, ovf=1, fifth dropped.
REQ-041 rst_pipe pulse in W_DONE -> next cycle IDLE, count 0, dma_io_we 0.
REQ-042 cnt=0 dir1 -> GO data 32'h2, W_DONE exits in first cycle run is low.
